// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
// Command front-end and result collector for the 16-bit ALU.
// Parses 5-byte frames (cmd, A_lo, A_hi, B_lo, B_hi) from a received byte
// stream, presents the operands and function code to the ALU as one atomic
// update, waits ALU_LAT cycles, captures the selected group's result and
// returns it as three bytes (result lo, result hi, status) on a
// valid/ready byte output.
//
// Ports:
//   CLK, RST                  clock (rising edge), async active-high reset
//   rx_data, rx_valid         incoming byte stream, no backpressure
//   tx_data, tx_valid,
//   tx_ready                  response byte stream, valid/ready handshake
//   busy                      high whenever a frame or response is in progress
//   frame_err                 1-cycle pulse: bad sync byte or inter-byte timeout
//   overrun                   1-cycle pulse: byte arrived while not accepting
//   alu_a, alu_b, alu_fun     operands and function code driven to the ALU
//   arith_out .. shift_out,
//   cmp_out, carry_out,
//   *_flag                    ALU group results and group-valid flags
module alu_cmd_ctrl #(
  parameter int          ALU_LAT = 2,
  parameter int          TIMEOUT = 1000,
  parameter logic [3:0]  SYNC    = 4'hA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_fun,
  input  logic [15:0] arith_out,
  input  logic [15:0] logic_out,
  input  logic [15:0] shift_out,
  input  logic        cmp_out,
  input  logic        carry_out,
  input  logic        arith_flag,
  input  logic        logic_flag,
  input  logic        cmp_flag,
  input  logic        shift_flag
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LW = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, GET_A0, GET_A1, GET_B0, GET_B1, WAIT, SEND_LO, SEND_HI, SEND_ST
  } state_t;

  state_t        state_q;
  logic [3:0]    fun_sh_q;
  logic [15:0]   a_sh_q;
  logic [7:0]    b_lo_sh_q;
  logic [15:0]   alu_a_q;
  logic [15:0]   alu_b_q;
  logic [3:0]    alu_fun_q;
  logic [TW-1:0] tmo_q;
  logic [LW-1:0] lat_q;
  logic [15:0]   result_q;
  logic [7:0]    status_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic [1:0]    grp_d;
  logic [15:0]   result_d;
  logic          flag_d;
  logic [7:0]    status_d;

  // Result and status as they would be captured this cycle; the group is
  // taken from the function code already presented to the ALU.
  always_comb begin
    grp_d    = alu_fun_q[3:2];
    result_d = arith_out;
    flag_d   = arith_flag;
    case (grp_d)
      2'b00: begin result_d = arith_out;         flag_d = arith_flag; end
      2'b01: begin result_d = logic_out;         flag_d = logic_flag; end
      2'b10: begin result_d = {15'b0, cmp_out};  flag_d = cmp_flag;   end
      default: begin result_d = shift_out;       flag_d = shift_flag; end
    endcase
    status_d = {(grp_d == 2'b00) ? carry_out : 1'b0, ~flag_d, grp_d, alu_fun_q};
  end

  // Frame parser, operand transfer, latency wait and response sequencer.
  // frame_err and overrun default low so each assertion is a single-cycle pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      fun_sh_q    <= '0;
      a_sh_q      <= '0;
      b_lo_sh_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      tmo_q       <= '0;
      lat_q       <= '0;
      result_q    <= '0;
      status_q    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data[7:4] == SYNC) begin
              fun_sh_q <= rx_data[3:0];
              tmo_q    <= '0;
              state_q  <= GET_A0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        GET_A0, GET_A1, GET_B0, GET_B1: begin
          // Timeout wins over a byte arriving on the same edge.
          if (tmo_q == TMO_LAST) begin
            frame_err_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= IDLE;
          end else if (rx_valid) begin
            tmo_q <= '0;
            case (state_q)
              GET_A0: begin a_sh_q[7:0]  <= rx_data; state_q <= GET_A1; end
              GET_A1: begin a_sh_q[15:8] <= rx_data; state_q <= GET_B0; end
              GET_B0: begin b_lo_sh_q    <= rx_data; state_q <= GET_B1; end
              default: begin
                // All ALU inputs change on the same edge so the ALU never
                // sees a mix of old and new operands.
                alu_a_q   <= a_sh_q;
                alu_b_q   <= {rx_data, b_lo_sh_q};
                alu_fun_q <= fun_sh_q;
                lat_q     <= '0;
                state_q   <= WAIT;
              end
            endcase
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        WAIT: begin
          overrun_q <= rx_valid;
          if (lat_q == LAT_LAST) begin
            result_q   <= result_d;
            status_q   <= status_d;
            tx_data_q  <= result_d[7:0];
            tx_valid_q <= 1'b1;
            state_q    <= SEND_LO;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end

        SEND_LO: begin
          overrun_q <= rx_valid;
          if (tx_ready) begin
            tx_data_q <= result_q[15:8];
            state_q   <= SEND_HI;
          end
        end

        SEND_HI: begin
          overrun_q <= rx_valid;
          if (tx_ready) begin
            tx_data_q <= status_q;
            state_q   <= SEND_ST;
          end
        end

        SEND_ST: begin
          overrun_q <= rx_valid;
          if (tx_ready) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl
// Testbench for alu_cmd_ctrl. The bench plays both the UART side and the ALU:
// the ALU outputs show inverted "wrong" values except during the single cycle
// before the expected capture edge, so a capture at the wrong time is visible.
// Expected response bytes come from a small reference model of the response
// rules (group select, status layout).
module tb_alu_cmd_ctrl;

  localparam int ALU_LAT = 2;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        frame_err;
  logic        overrun;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] arithDrv = '0;
  logic [15:0] logicDrv = '0;
  logic [15:0] shiftDrv = '0;
  logic        cmpDrv = 1'b0;
  logic        carryDrv = 1'b0;
  logic [3:0]  flagDrv = '0;

  // Intended ALU values for the frame in flight; flag bits are
  // [0] arith, [1] logic, [2] cmp, [3] shift.
  logic [15:0] aluArith, aluLogic, aluShift;
  logic        aluCmp, aluCarry;
  logic [3:0]  aluFlags;

  int checks = 0;
  int errors = 0;

  alu_cmd_ctrl #(.ALU_LAT(ALU_LAT), .TIMEOUT(TIMEOUT), .SYNC(4'hA)) dut (
    .CLK(CLK), .RST(RST),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arithDrv), .logic_out(logicDrv), .shift_out(shiftDrv),
    .cmp_out(cmpDrv), .carry_out(carryDrv),
    .arith_flag(flagDrv[0]), .logic_flag(flagDrv[1]),
    .cmp_flag(flagDrv[2]), .shift_flag(flagDrv[3])
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte on the RX strobe, consumed by the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic driveReal();
    arithDrv = aluArith; logicDrv = aluLogic; shiftDrv = aluShift;
    cmpDrv = aluCmp; carryDrv = aluCarry; flagDrv = aluFlags;
  endtask

  task automatic driveGarbage();
    arithDrv = ~aluArith; logicDrv = ~aluLogic; shiftDrv = ~aluShift;
    cmpDrv = ~aluCmp; carryDrv = ~aluCarry; flagDrv = ~aluFlags;
  endtask

  task automatic setAlu(input logic [15:0] ar, input logic [15:0] lo, input logic [15:0] sh,
                        input logic cm, input logic cy, input logic [3:0] fl);
    aluArith = ar; aluLogic = lo; aluShift = sh; aluCmp = cm; aluCarry = cy; aluFlags = fl;
  endtask

  // Reference response: {status, result_hi, result_lo}.
  function automatic logic [23:0] modelResponse(input logic [3:0] fun);
    logic [1:0]  grp;
    logic [15:0] res;
    logic        carryBit;
    grp = fun[3:2];
    carryBit = 1'b0;
    case (grp)
      2'd0: begin res = aluArith; carryBit = aluCarry; end
      2'd1: res = aluLogic;
      2'd2: res = {15'b0, aluCmp};
      default: res = aluShift;
    endcase
    return {carryBit, ~aluFlags[grp], grp, fun, res[15:8], res[7:0]};
  endfunction

  // Full frame: send, check operand transfer, check capture timing, then
  // drain the three response bytes under the chosen tx_ready pattern.
  task automatic runFrame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          input int gap, input bit randGap, input int stallLo,
                          input bit randReady, input bit injectOverrun);
    logic [23:0] resp;
    logic [7:0]  frameBytes[5];
    logic [7:0]  expBytes[3];
    int          got, budget, stallLeft, gapNow;
    bit          rdy, orv;
    resp = modelResponse(cmd[3:0]);
    expBytes[0] = resp[7:0];
    expBytes[1] = resp[15:8];
    expBytes[2] = resp[23:16];
    frameBytes[0] = cmd;     frameBytes[1] = a[7:0]; frameBytes[2] = a[15:8];
    frameBytes[3] = b[7:0];  frameBytes[4] = b[15:8];
    driveGarbage();
    for (int i = 0; i < 5; i++) begin
      gapNow = (i == 0) ? 0 : (randGap ? $urandom_range(0, gap) : gap);
      repeat (gapNow) tick();
      applyStimulus(frameBytes[i]);
      checkOutput("frameErrOnByte", {31'b0, frame_err}, 32'd0);
    end
    checkOutput("aluA", {16'b0, alu_a}, {16'b0, a});
    checkOutput("aluB", {16'b0, alu_b}, {16'b0, b});
    checkOutput("aluFun", {28'b0, alu_fun}, {28'b0, cmd[3:0]});
    checkOutput("busyWait", {31'b0, busy}, 32'd1);
    checkOutput("txValidWait", {31'b0, tx_valid}, 32'd0);
    for (int k = 1; k <= ALU_LAT; k++) begin
      if (k == ALU_LAT) driveReal();
      orv = injectOverrun ? 1'($urandom_range(0, 1)) : 1'b0;
      rx_data  = 8'($urandom);
      rx_valid = orv;
      tick();
      rx_valid = 1'b0;
      checkOutput("overrunWait", {31'b0, overrun}, {31'b0, orv});
      if (k < ALU_LAT) checkOutput("txValidEarly", {31'b0, tx_valid}, 32'd0);
    end
    driveGarbage();
    got = 0;
    budget = 200;
    stallLeft = stallLo;
    while (got < 3 && budget > 0) begin
      checkOutput("txValidSend", {31'b0, tx_valid}, 32'd1);
      checkOutput("txByte", {24'b0, tx_data}, {24'b0, expBytes[got]});
      if (stallLeft > 0) begin
        rdy = 1'b0;
        stallLeft--;
      end else begin
        rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      orv = injectOverrun ? 1'($urandom_range(0, 1)) : 1'b0;
      tx_ready = rdy;
      rx_data  = 8'($urandom);
      rx_valid = orv;
      tick();
      rx_valid = 1'b0;
      checkOutput("overrunSend", {31'b0, overrun}, {31'b0, orv});
      checkOutput("frameErrSend", {31'b0, frame_err}, 32'd0);
      if (rdy) got++;
      budget--;
    end
    tx_ready = 1'b0;
    checkOutput("sendBudget", got, 3);
    checkOutput("txValidDone", {31'b0, tx_valid}, 32'd0);
    checkOutput("busyDone", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [3:0]  fun;
    logic [7:0]  bad;
    logic [23:0] resp;

    setAlu('0, '0, '0, 1'b0, 1'b0, 4'h0);

    // Reset state
    tick();
    tick();
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstTxValid", {31'b0, tx_valid}, 32'd0);
    checkOutput("rstTxData", {24'b0, tx_data}, 32'd0);
    checkOutput("rstFrameErr", {31'b0, frame_err}, 32'd0);
    checkOutput("rstOverrun", {31'b0, overrun}, 32'd0);
    checkOutput("rstAluA", {16'b0, alu_a}, 32'd0);
    checkOutput("rstAluB", {16'b0, alu_b}, 32'd0);
    checkOutput("rstAluFun", {28'b0, alu_fun}, 32'd0);
    RST = 1'b0;
    tick();

    // ADD: 0F 00 00
    setAlu(16'h000F, 16'h1234, 16'h5678, 1'b1, 1'b0, 4'hF);
    runFrame(8'hA0, 16'h000A, 16'h0005, 0, 1'b0, 0, 1'b0, 1'b0);

    // AND with flag set then cleared: status 14 then 54
    setAlu(16'h0F0F, 16'h0000, 16'h5678, 1'b0, 1'b1, 4'hF);
    runFrame(8'hA4, 16'h000A, 16'h0005, 0, 1'b0, 0, 1'b0, 1'b0);
    setAlu(16'h0F0F, 16'h0000, 16'h5678, 1'b0, 1'b1, 4'hD);
    runFrame(8'hA4, 16'h000A, 16'h0005, 0, 1'b0, 0, 1'b0, 1'b0);

    // Bad sync byte, then a normal frame
    applyStimulus(8'h50);
    checkOutput("badSyncErr", {31'b0, frame_err}, 32'd1);
    checkOutput("badSyncBusy", {31'b0, busy}, 32'd0);
    checkOutput("badSyncOverrun", {31'b0, overrun}, 32'd0);
    tick();
    checkOutput("badSyncPulse", {31'b0, frame_err}, 32'd0);
    checkOutput("badSyncNoTx", {31'b0, tx_valid}, 32'd0);
    setAlu(16'h000F, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 4'hF);
    runFrame(8'hA0, 16'h000A, 16'h0005, 0, 1'b0, 0, 1'b0, 1'b0);

    // Timeout after the second byte; operands from the last frame stay put
    applyStimulus(8'hA5);
    applyStimulus(8'h33);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < TIMEOUT + 5) begin
      tick();
      cnt++;
      if (frame_err === 1'b1) seen = 1'b1;
    end
    checkOutput("timeoutCycles", cnt, TIMEOUT);
    checkOutput("timeoutBusy", {31'b0, busy}, 32'd0);
    checkOutput("timeoutOverrun", {31'b0, overrun}, 32'd0);
    checkOutput("timeoutAluA", {16'b0, alu_a}, 32'h000A);
    checkOutput("timeoutAluB", {16'b0, alu_b}, 32'h0005);
    checkOutput("timeoutAluFun", {28'b0, alu_fun}, 32'd0);
    tick();
    checkOutput("timeoutPulse", {31'b0, frame_err}, 32'd0);

    // A byte landing on the timeout edge is dropped
    applyStimulus(8'hA0);
    applyStimulus(8'h11);
    repeat (TIMEOUT - 1) tick();
    applyStimulus(8'h22);
    checkOutput("timeoutEdgeErr", {31'b0, frame_err}, 32'd1);
    checkOutput("timeoutEdgeBusy", {31'b0, busy}, 32'd0);
    tick();

    // Longest legal inter-byte gap, then backpressure with overrun traffic
    setAlu(16'h000F, 16'h0101, 16'h0202, 1'b1, 1'b1, 4'h1);
    runFrame(8'hA0, 16'hBEEF, 16'hCAFE, TIMEOUT - 2, 1'b0, 0, 1'b0, 1'b0);
    runFrame(8'hA0, 16'h000A, 16'h0005, 0, 1'b0, 5, 1'b0, 1'b1);

    // Reset while the high result byte is on offer
    setAlu(16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'hF);
    driveReal();
    resp = modelResponse(4'h0);
    applyStimulus(8'hA0);
    applyStimulus(8'h77);
    applyStimulus(8'h66);
    applyStimulus(8'h55);
    applyStimulus(8'h44);
    tx_ready = 1'b1;
    cnt = 0;
    while (tx_valid !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    tick();
    tx_ready = 1'b0;
    checkOutput("midSendValid", {31'b0, tx_valid}, 32'd1);
    checkOutput("midSendHi", {24'b0, tx_data}, {24'b0, resp[15:8]});
    #2 RST = 1'b1;
    #1;
    checkOutput("asyncRstTxValid", {31'b0, tx_valid}, 32'd0);
    checkOutput("asyncRstBusy", {31'b0, busy}, 32'd0);
    checkOutput("asyncRstAluA", {16'b0, alu_a}, 32'd0);
    checkOutput("asyncRstAluB", {16'b0, alu_b}, 32'd0);
    checkOutput("asyncRstAluFun", {28'b0, alu_fun}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    setAlu(16'h000F, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'hF);
    runFrame(8'hA0, 16'h000A, 16'h0005, 0, 1'b0, 0, 1'b0, 1'b0);

    // Randomized frames with random gaps, stalls, bad syncs and overrun bytes
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bad = 8'($urandom);
        if (bad[7:4] == 4'hA) bad[7:4] = 4'h5;
        applyStimulus(bad);
        checkOutput("randBadSync", {31'b0, frame_err}, 32'd1);
        checkOutput("randBadSyncBusy", {31'b0, busy}, 32'd0);
      end
      setAlu(16'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), 4'($urandom));
      fun = 4'($urandom);
      runFrame({4'hA, fun}, 16'($urandom), 16'($urandom), TIMEOUT - 2, 1'b1,
               $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
